// File: rtl/audio_echo_stage.sv
`default_nettype none
// ============================================================================
// Module   : audio_echo_stage
// Purpose  : Stereo feedback echo mixing each sample with its own delayed,
//            attenuated output held in per-channel circular RAMs.
// Revision : 1.0 - initial release
// ============================================================================
module audio_echo_stage #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 24
) (
   input  logic              clk_48,
   input  logic              rst,
   input  logic [DATA_W-1:0] line_in_l,
   input  logic [DATA_W-1:0] line_in_r,
   input  logic              new_sample,
   input  logic [ADDR_W-1:0] delay_len,
   input  logic [7:0]        fb_gain,
   input  logic              bypass,
   output logic [DATA_W-1:0] hphone_l,
   output logic [DATA_W-1:0] hphone_r,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int PW = DATA_W + 9;

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_RD   = 3'd1;
   localparam logic [2:0] c_MUL  = 3'd2;
   localparam logic [2:0] c_SUM  = 3'd3;
   localparam logic [2:0] c_WR   = 3'd4;

   localparam logic signed [PW-1:0] c_SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PW-1:0] c_SAT_MIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic [ADDR_W-1:0]    c_FILL_MAX = {ADDR_W{1'b1}};

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] wp_q, fill_q, delay_q;
   logic [7:0]        gain_q;
   logic              bypass_q, overrun_q;

   logic              w_capture, w_ram_re, w_ram_we, w_ld_prod, w_ld_out;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_dry_only;

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk_48 or posedge rst) begin
      if (rst) state_q <= c_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:  if (new_sample) state_d = c_RD;
         c_RD:    state_d = c_MUL;
         c_MUL:   state_d = c_SUM;
         c_SUM:   state_d = c_WR;
         c_WR:    state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      w_capture = (state_q == c_IDLE) && new_sample;
      w_ram_re  = (state_q == c_RD);
      w_ld_prod = (state_q == c_MUL);
      w_ld_out  = (state_q == c_SUM);
      w_ram_we  = (state_q == c_WR);
      out_valid = (state_q == c_WR);
      busy      = (state_q != c_IDLE);
   end

   // ------------------------------------------------------ shared control
   always_ff @(posedge clk_48 or posedge rst) begin
      if (rst) begin
         wp_q      <= '0;
         fill_q    <= '0;
         delay_q   <= '0;
         gain_q    <= '0;
         bypass_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (w_capture) begin
            delay_q  <= delay_len;
            gain_q   <= fb_gain;
            bypass_q <= bypass;
         end
         if (w_ram_we) begin
            wp_q <= wp_q + 1'b1;
            if (fill_q != c_FILL_MAX) fill_q <= fill_q + 1'b1;
         end
         if (new_sample && busy) overrun_q <= 1'b1;
      end
   end

   assign w_rd_addr  = wp_q - delay_q;
   // Slots not yet written since reset hold stale data and must not echo.
   assign w_dry_only = (delay_q == '0) || (fill_q < delay_q) || bypass_q;
   assign overrun    = overrun_q;

   // -------------------------------------------------- per-channel datapath
   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [DATA_W-1:0]        mem [2**ADDR_W];
      logic [DATA_W-1:0]        rdata_q;
      logic [DATA_W-1:0]        in_q;
      logic [DATA_W-1:0]        hphone_q;
      logic signed [PW-1:0]     prod_q;
      logic [DATA_W-1:0]        w_line;
      logic [DATA_W-1:0]        w_d;
      logic signed [PW-1:0]     w_d_ext, w_gain_ext, w_wet, w_in_ext, w_sum;
      logic [DATA_W-1:0]        w_sat;

      assign w_line = (ch == 0) ? line_in_l : line_in_r;

      always_ff @(posedge clk_48) begin
         if (w_ram_we) mem[wp_q] <= hphone_q;
         if (w_ram_re) rdata_q <= mem[w_rd_addr];
      end

      assign w_d        = w_dry_only ? '0 : rdata_q;
      assign w_d_ext    = $signed({{(PW-DATA_W){w_d[DATA_W-1]}}, w_d});
      assign w_gain_ext = $signed({{(PW-8){1'b0}}, gain_q});
      assign w_wet      = prod_q >>> 8;
      assign w_in_ext   = $signed({{(PW-DATA_W){in_q[DATA_W-1]}}, in_q});
      assign w_sum      = w_in_ext + w_wet;

      always_comb begin
         w_sat = w_sum[DATA_W-1:0];
         if (w_sum > c_SAT_MAX)      w_sat = c_SAT_MAX[DATA_W-1:0];
         else if (w_sum < c_SAT_MIN) w_sat = c_SAT_MIN[DATA_W-1:0];
      end

      always_ff @(posedge clk_48 or posedge rst) begin
         if (rst) begin
            in_q     <= '0;
            prod_q   <= '0;
            hphone_q <= '0;
         end else begin
            if (w_capture) in_q     <= w_line;
            if (w_ld_prod) prod_q   <= w_d_ext * w_gain_ext;
            if (w_ld_out)  hphone_q <= w_sat;
         end
      end
   end

   assign hphone_l = g_ch[0].hphone_q;
   assign hphone_r = g_ch[1].hphone_q;

endmodule
`default_nettype wire
